// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory port arbiter: port IDs, default widths.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dmem_arb_pkg;

    localparam int ADDR_W_DEF       = 32;
    localparam int DATA_W_DEF       = 32;
    localparam int STARVE_LIMIT_DEF = 4;
    localparam int STARVE_CNT_W     = 8;

    // Identifies which requester owns an in-flight read.
    typedef enum logic {
        PORT_CPU = 1'b0,
        PORT_DBG = 1'b1
    } port_id_e;

endpackage

// File: rtl/dmem_arb_grant.sv
// Fixed-priority grant (port 0 wins) with an anti-starvation counter for port 1.
// Latency: grants are combinational; the counter updates on each rising edge.
// Backpressure: the refused port simply sees grant low and must hold its request.
//
// Ports: clk, rst_n (async active-low); req0_valid/req1_valid requests in;
//        grant0/grant1 out (at most one high).
module dmem_arb_grant
    import dmem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req0_valid,
    input  logic req1_valid,
    output logic grant0,
    output logic grant1
);

    localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

    logic [STARVE_CNT_W-1:0] starve_cnt_q;
    logic [STARVE_CNT_W-1:0] starve_cnt_d;
    logic                    force1;

    assign force1 = (starve_cnt_q >= LIMIT);

    always_comb begin
        grant1       = req1_valid & (force1 | ~req0_valid);
        grant0       = req0_valid & ~grant1;
        starve_cnt_d = starve_cnt_q;
        // Credit never carries over: a withdrawn port 1 request restarts the count.
        if (!req1_valid || grant1) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != '1) begin
            starve_cnt_d = starve_cnt_q + STARVE_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares one data-memory port between the CPU (port 0) and a debug/DMA loader (port 1).
// Latency: request to memory is combinational; read data returns 1 cycle after accept.
// Backpressure: reqN_ready low refuses the request; responses cannot be stalled.
//
// Ports: clk, rst_n (async active-low);
//        reqN_valid/ready/we/addr/wdata  request side, N = 0,1;
//        rspN_valid/rdata                read response side;
//        mem_addr_r/addr_w/read/write/wdata, mem_rdata  memory with registered read.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,

    output logic [ADDR_W-1:0] mem_addr_r,
    output logic [ADDR_W-1:0] mem_addr_w,
    output logic              mem_read,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic     grant0;
    logic     grant1;
    logic     pending_q;
    logic     pending_d;
    port_id_e owner_q;
    port_id_e owner_d;

    dmem_arb_grant #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_grant (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .grant0     (grant0),
        .grant1     (grant1)
    );

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Memory mux: drives are zero whenever nothing is granted.
    always_comb begin
        mem_addr_r = '0;
        mem_addr_w = '0;
        mem_wdata  = '0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        if (grant1) begin
            mem_addr_r = req1_addr;
            mem_addr_w = req1_addr;
            mem_wdata  = req1_wdata;
            mem_read   = ~req1_we;
            mem_write  = req1_we;
        end else if (grant0) begin
            mem_addr_r = req0_addr;
            mem_addr_w = req0_addr;
            mem_wdata  = req0_wdata;
            mem_read   = ~req0_we;
            mem_write  = req0_we;
        end
    end

    // Track the single read that can be in flight; owner only moves on a read accept.
    always_comb begin
        pending_d = mem_read;
        owner_d   = owner_q;
        if (mem_read) begin
            owner_d = grant1 ? PORT_DBG : PORT_CPU;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= 1'b0;
            owner_q   <= PORT_CPU;
        end else begin
            pending_q <= pending_d;
            owner_q   <= owner_d;
        end
    end

    // Memory output is already registered, so read data is passed straight through.
    always_comb begin
        rsp0_valid = pending_q & (owner_q == PORT_CPU);
        rsp1_valid = pending_q & (owner_q == PORT_DBG);
        rsp0_rdata = rsp0_valid ? mem_rdata : '0;
        rsp1_rdata = rsp1_valid ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed scenarios plus randomized traffic.
// Latency: n/a.
// Backpressure: requests are held until accepted, except where a withdrawal is exercised.
module tb_dmem_port_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req0_we = 1'b0;
    logic [31:0] req0_addr = '0, req0_wdata = '0;
    logic        req1_valid = 1'b0, req1_we = 1'b0;
    logic [31:0] req1_addr = '0, req1_wdata = '0;
    logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
    logic [31:0] rsp0_rdata, rsp1_rdata;
    logic [31:0] mem_addr_r, mem_addr_w, mem_wdata;
    logic        mem_read, mem_write;
    logic [31:0] mem_rdata = '0;

    int n_cmp = 0;
    int n_bad = 0;

    dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_we    (req0_we),
        .req0_addr  (req0_addr),
        .req0_wdata (req0_wdata),
        .rsp0_valid (rsp0_valid),
        .rsp0_rdata (rsp0_rdata),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_we    (req1_we),
        .req1_addr  (req1_addr),
        .req1_wdata (req1_wdata),
        .rsp1_valid (rsp1_valid),
        .rsp1_rdata (rsp1_rdata),
        .mem_addr_r (mem_addr_r),
        .mem_addr_w (mem_addr_w),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory stub with registered read, driven only by the DUT's memory outputs.
    logic [31:0] smem [16];
    always @(posedge clk) begin
        if (mem_write) smem[mem_addr_w[3:0]] <= mem_wdata;
        if (mem_read)  mem_rdata <= smem[mem_addr_r[3:0]];
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // refused: consecutive cycles port 1 has asked and been turned away.
    int          refused = 0;
    bit          m_pend = 1'b0;
    bit          m_own = 1'b0;
    logic [31:0] m_data = '0;
    logic [31:0] refmem [16];

    always @(negedge clk) begin
        bit          g0, g1, rd;
        logic [31:0] e_addr, e_wd;
        bit          e_we;
        if (!rst_n) begin
            refused = 0;
            m_pend  = 1'b0;
        end
        g1 = req1_valid && (refused >= LIMIT || !req0_valid);
        g0 = req0_valid && !g1;
        e_addr = g1 ? req1_addr  : (g0 ? req0_addr  : 32'h0);
        e_wd   = g1 ? req1_wdata : (g0 ? req0_wdata : 32'h0);
        e_we   = g1 ? req1_we    : (g0 ? req0_we    : 1'b0);
        rd     = (g0 || g1) && !e_we;
        chk("ready0", req0_ready, g0);
        chk("ready1", req1_ready, g1);
        chk("mem_addr_r", mem_addr_r, e_addr);
        chk("mem_addr_w", mem_addr_w, e_addr);
        chk("mem_wdata", mem_wdata, e_wd);
        chk("mem_read", mem_read, rd);
        chk("mem_write", mem_write, (g0 || g1) && e_we);
        chk("rsp0_valid", rsp0_valid, m_pend && !m_own);
        chk("rsp1_valid", rsp1_valid, m_pend && m_own);
        chk("rsp0_rdata", rsp0_rdata, (m_pend && !m_own) ? m_data : 32'h0);
        chk("rsp1_rdata", rsp1_rdata, (m_pend && m_own) ? m_data : 32'h0);
        if (rst_n) begin
            // State after the coming rising edge.
            m_pend = rd;
            if (rd) begin
                m_own  = g1;
                m_data = refmem[e_addr[3:0]];
            end
            if ((g0 || g1) && e_we) refmem[e_addr[3:0]] = e_wd;
            if (!req1_valid || g1) refused = 0;
            else if (refused < 255) refused = refused + 1;
        end
    end

    // ---------------- stimulus ----------------
    logic s_r0, s_r1;

    task automatic set_req(input logic v0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                           input logic v1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
        req0_valid = v0; req0_we = w0; req0_addr = a0; req0_wdata = d0;
        req1_valid = v1; req1_we = w1; req1_addr = a1; req1_wdata = d1;
    endtask

    // One cycle: capture readiness away from the edge, then move just past the edge.
    task automatic step();
        @(negedge clk);
        s_r0 = req0_ready;
        s_r1 = req1_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        set_req(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        logic [9:0] pat;
        int         waits;
        logic       v0, w0, v1, w1;
        logic [31:0] a0, d0, a1, d1;

        for (int i = 0; i < 16; i++) begin
            smem[i]   = 32'h0;
            refmem[i] = 32'h0;
        end
        smem[3]   = 32'h0000_1234;
        refmem[3] = 32'h0000_1234;

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("reset_rsp0_valid", rsp0_valid, 1'b0);
        chk("reset_rsp1_valid", rsp1_valid, 1'b0);
        chk("reset_mem_read", mem_read, 1'b0);
        chk("reset_mem_write", mem_write, 1'b0);
        step();

        // Port 0 write then read of address 5.
        set_req(1, 1, 5, 32'hDEAD_BEEF, 0, 0, 0, 0);
        step();
        chk("t2_ready0_wr", s_r0, 1'b1);
        set_req(1, 0, 5, 0, 0, 0, 0, 0);
        step();
        chk("t2_ready0_rd", s_r0, 1'b1);
        idle();
        #1;
        chk("t2_rsp0_valid", rsp0_valid, 1'b1);
        chk("t2_rsp0_rdata", rsp0_rdata, 32'hDEAD_BEEF);
        chk("t2_rsp1_valid", rsp1_valid, 1'b0);
        step();

        // Port 1 alone reads preloaded address 3.
        set_req(0, 0, 0, 0, 1, 0, 3, 0);
        step();
        chk("t4_ready1", s_r1, 1'b1);
        idle();
        #1;
        chk("t4_rsp1_valid", rsp1_valid, 1'b1);
        chk("t4_rsp1_rdata", rsp1_rdata, 32'h1234);
        step();

        // Back-to-back mixed traffic, then read-after-write on consecutive cycles.
        set_req(1, 0, 1, 0, 0, 0, 0, 0);
        step();
        set_req(0, 0, 0, 0, 1, 0, 2, 0);
        #1;
        chk("t5_rsp0_after_rd0", rsp0_valid, 1'b1);
        step();
        set_req(1, 1, 1, 32'h0000_00AA, 0, 0, 0, 0);
        #1;
        chk("t5_rsp1_after_rd1", rsp1_valid, 1'b1);
        chk("t5_rsp0_quiet", rsp0_valid, 1'b0);
        step();
        set_req(1, 0, 1, 0, 0, 0, 0, 0);
        #1;
        chk("t5_no_rsp_for_write", rsp0_valid | rsp1_valid, 1'b0);
        step();
        idle();
        #1;
        chk("t5_raw_rdata", rsp0_rdata, 32'h0000_00AA);
        step();

        // Both request continuously: port 1 forced every fifth cycle.
        pat = 10'b10000_10000;
        set_req(1, 0, 0, 0, 1, 0, 2, 0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("t3_grant1_cycle%0d", i), s_r1, pat[i]);
        end
        idle();
        step();

        // Port 1 refused 3 cycles, withdraws for 1, returns: must wait 4 more.
        set_req(1, 0, 0, 0, 1, 0, 4, 0);
        for (int i = 0; i < 3; i++) step();
        set_req(1, 0, 0, 0, 0, 0, 0, 0);
        step();
        set_req(1, 0, 0, 0, 1, 0, 4, 0);
        waits = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (s_r1) break;
            waits++;
        end
        chk("t6_refused_before_force", waits, 4);
        idle();
        step();

        // Reset while a read is in flight.
        set_req(1, 0, 5, 0, 0, 0, 0, 0);
        step();
        idle();
        #1;
        chk("t1_pre_reset_rsp0", rsp0_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t1_reset_rsp0_valid", rsp0_valid, 1'b0);
        chk("t1_reset_rsp1_valid", rsp1_valid, 1'b0);
        chk("t1_reset_rsp0_rdata", rsp0_rdata, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("t1_release_rsp0_valid", rsp0_valid, 1'b0);
        step();
        step();

        // Randomized traffic; requests held until accepted.
        v0 = 0; w0 = 0; a0 = 0; d0 = 0;
        v1 = 0; w1 = 0; a1 = 0; d1 = 0;
        s_r0 = 1'b0; s_r1 = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (!v0 || s_r0) begin
                v0 = ($urandom_range(0, 3) != 0);
                w0 = $urandom_range(0, 1);
                a0 = $urandom_range(0, 15);
                d0 = $urandom;
            end
            if (!v1 || s_r1) begin
                v1 = ($urandom_range(0, 1) != 0);
                w1 = $urandom_range(0, 1);
                a1 = $urandom_range(0, 15);
                d1 = $urandom;
            end
            set_req(v0, w0, a0, d0, v1, w1, a1, d1);
            step();
        end
        idle();
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
